// File: rtl/fp_mul_pkg.sv
// Shared widths, rounding-mode type and ID sizing for the shared FP multiplier arbiter.
package fp_mul_pkg;
  localparam int SIGN_W_DEF = 1;
  localparam int EXPO_W_DEF = 8;
  localparam int MANT_W_DEF = 23;

  typedef logic [1:0] rnd_t;

  function automatic int id_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fp_mul_arb_rr_arbiter.sv
// Round-robin arbiter: first asserted req searching upward from ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    // walk offsets high to low so the nearest request to ptr wins last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      automatic int idx = (int'(ptr) + k) % NUM_REQ;
      if (en && req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/mul_para.sv
// Combinational parameterised FP multiplier; denormals flush to zero.
// rnd: 00 nearest-even, 01 toward zero, 10 toward -inf, 11 toward +inf.
module mul_para #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] b,
  input  logic [1:0]                      rnd,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0] res
);
  localparam int FP_W = SIGN_W + EXPO_W + MANT_W;
  localparam int PW   = 2 * (MANT_W + 1);
  localparam int EW   = EXPO_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXPO_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXPO_W) - 1);

  logic              sgn, zero_a, zero_b, inf_a, inf_b, nan_in, grd, stk, inc;
  logic [EXPO_W-1:0] ea, eb;
  logic [PW-1:0]     ma, mb, prod;
  logic [PW-2:0]     norm;
  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]   mant_r;
  logic [EW-1:0]     e, e_r;

  always_comb begin
    sgn    = a[FP_W-1] ^ b[FP_W-1];
    ea     = a[MANT_W +: EXPO_W];
    eb     = b[MANT_W +: EXPO_W];
    zero_a = (ea == '0);
    zero_b = (eb == '0);
    inf_a  = (ea == '1);
    inf_b  = (eb == '1);
    nan_in = (inf_a & |a[MANT_W-1:0]) | (inf_b & |b[MANT_W-1:0]) |
             (inf_a & zero_b) | (inf_b & zero_a);
    ma     = {{(MANT_W+1){1'b0}}, 1'b1, a[MANT_W-1:0]};
    mb     = {{(MANT_W+1){1'b0}}, 1'b1, b[MANT_W-1:0]};
    prod   = ma * mb;
    // product of two [1,2) significands lies in [1,4): one-bit normalise
    norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    mant   = norm[PW-2 -: MANT_W];
    grd    = norm[PW-2-MANT_W];
    stk    = |norm[PW-3-MANT_W:0];
    case (rnd)
      2'b00:   inc = grd & (stk | mant[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = sgn & (grd | stk);
      default: inc = ~sgn & (grd | stk);
    endcase
    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    e      = {2'b00, ea} + {2'b00, eb} + {{(EW-1){1'b0}}, prod[PW-1]} - BIAS;
    e_r    = e + {{(EW-1){1'b0}}, mant_r[MANT_W]};
    if (nan_in)
      res = {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    else if (inf_a | inf_b)
      res = {{SIGN_W{sgn}}, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    else if (zero_a | zero_b | e_r[EW-1] | (e_r == '0))
      res = {{SIGN_W{sgn}}, {(EXPO_W+MANT_W){1'b0}}};
    else if (e_r >= EMAX)
      res = {{SIGN_W{sgn}}, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    else
      res = {{SIGN_W{sgn}}, e_r[EXPO_W-1:0], mant_r[MANT_W-1:0]};
  end
endmodule

// File: rtl/fp_mul_arb.sv
// Round-robin share of one mul_para between NUM_REQ requesters; issue and
// result registers with full backpressure, results tagged by requester id.
module fp_mul_arb
  import fp_mul_pkg::*;
#(
  parameter int SIGN_W  = SIGN_W_DEF,
  parameter int EXPO_W  = EXPO_W_DEF,
  parameter int MANT_W  = MANT_W_DEF,
  parameter int NUM_REQ = 4,
  localparam int FP_W   = SIGN_W + EXPO_W + MANT_W,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]    req_rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP_W-1:0]         out_res,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    rnd_t            rnd;
    logic [ID_W-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [FP_W-1:0] res;
    logic [ID_W-1:0] id;
  } s2_t;

  logic [2:1]                    vld_pipe;
  s1_t                           s1;
  s2_t                           s2;
  logic [ID_W-1:0]               rr_ptr, gnt_id;
  logic [NUM_REQ-1:0]            gnt;
  logic                          s1_adv, s2_adv, accept;
  logic [FP_W-1:0]               mul_res;
  logic [NUM_REQ-1:0][FP_W-1:0]  a_arr, b_arr;
  rnd_t [NUM_REQ-1:0]            rnd_arr;

  assign a_arr   = req_a;
  assign b_arr   = req_b;
  assign rnd_arr = req_rnd;

  assign s2_adv = !vld_pipe[2] | out_ready;
  assign s1_adv = !vld_pipe[1] | s2_adv;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (s1_adv & !rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  mul_para #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_mul (
    .a   (s1.a),
    .b   (s1.b),
    .rnd (s1.rnd),
    .res (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= accept;
        if (accept) begin
          s1     <= '{a: a_arr[gnt_id], b: b_arr[gnt_id], rnd: rnd_arr[gnt_id], id: gnt_id};
          rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
      // s2 payload holds when it drains without a replacement
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= '{res: mul_res, id: s1.id};
      end
    end
  end

  assign out_valid = vld_pipe[2] & !rst;
  assign out_res   = s2.res;
  assign out_id    = s2.id;
  assign busy      = vld_pipe[1] | vld_pipe[2];
endmodule

// File: tb/tb_fp_mul_arb.sv
// Scoreboard bench for fp_mul_arb: expected products queued on accept, checked on output.
module tb_fp_mul_arb;
  localparam int N    = 4;
  localparam int FW   = 32;
  localparam int NENT = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*FW-1:0] req_a, req_b;
  logic [N*2-1:0]  req_rnd;
  logic            out_valid, out_ready, busy;
  logic [FW-1:0]   out_res;
  logic [1:0]      out_id;

  always #5 clk = ~clk;

  fp_mul_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_id(out_id), .busy(busy)
  );

  logic [31:0] tbl_a [NENT] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h3F000000, 32'h40A00000,
                                32'h00000000, 32'h41200000, 32'h3FC00000, 32'h3F800001, 32'h3F800001};
  logic [31:0] tbl_b [NENT] = '{32'h40000000, 32'hC0000000, 32'h40800000, 32'h3F000000, 32'hBF800000,
                                32'h40000000, 32'h41200000, 32'h3FC00000, 32'h3F800001, 32'h3F800001};
  logic [1:0]  tbl_r [NENT] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
  logic [31:0] tbl_e [NENT] = '{32'h40000000, 32'hC0400000, 32'h41400000, 32'h3E800000, 32'hC0A00000,
                                32'h00000000, 32'h42C80000, 32'h40100000, 32'h3F800003, 32'h3F800002};

  typedef struct {
    logic [31:0] res;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          n_tests = 0, n_fail = 0, n_pop = 0;
  logic [N-1:0] acc_last = '0;
  int          ent [N];
  int          rem [N];
  logic [31:0] exp_res [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gl(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : -1;
  endfunction

  task automatic load(input int i);
    req_a[i*FW +: FW] = tbl_a[ent[i]];
    req_b[i*FW +: FW] = tbl_b[ent[i]];
    req_rnd[i*2 +: 2] = tbl_r[ent[i]];
    exp_res[i]        = tbl_e[ent[i]];
    req_valid[i]      = 1'b1;
  endtask

  task automatic start(input int i, input int e, input int r);
    ent[i] = e;
    rem[i] = r;
    load(i);
  endtask

  // advance one clock; accepted requesters move to their next operand or drop valid
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_last[i]) begin
        if (rem[i] > 1) begin
          rem[i]--;
          ent[i] = (ent[i] + 1) % NENT;
          load(i);
        end else begin
          rem[i]       = 0;
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && k < 60) begin
      step();
      k++;
    end
    #1;
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("out_res", out_res, e.res);
        chk("out_id", out_id, e.id);
        n_pop++;
      end
    end
    acc_last = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (acc_last[i]) begin
        sb.push_back('{exp_res[i], 2'(i)});
        gnt_log.push_back(i);
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_rnd = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin ent[i] = 0; rem[i] = 0; exp_res[i] = '0; end

    // reset: ready and valid gated even with requests pending
    @(posedge clk); #1;
    req_valid = '1; #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_ovalid", out_valid, 1'b0);
    req_valid = '0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", out_res, 32'h0);
    chk("rst_id", out_id, 2'd0);

    // single requester, two-cycle latency
    start(0, 0, 1); #1;
    chk("t1_ready", req_ready, 4'b0001);
    step(); #1;
    chk("t1_lat1", out_valid, 1'b0);
    chk("t1_busy", busy, 1'b1);
    step(); #1;
    chk("t1_ovalid", out_valid, 1'b1);
    chk("t1_res", out_res, 32'h40000000);
    chk("t1_id", out_id, 2'd0);
    drain();

    // sign path from requester 2
    start(2, 1, 1);
    step(); step(); #1;
    chk("t2_res", out_res, 32'hC0400000);
    chk("t2_id", out_id, 2'd2);
    drain();

    // wrap: pointer sits at 3
    gnt_log.delete();
    start(3, 2, 1); start(0, 3, 1);
    step(); step();
    chk("wrap_g0", gl(0), 3);
    chk("wrap_g1", gl(1), 0);
    drain();
    gnt_log.delete();
    start(0, 4, 1); start(1, 5, 1);
    step();
    chk("wrap_ptr1", gl(0), 1);
    drain();

    // backpressure: three ops from requester 1, consumer stalled
    out_ready = 1'b0;
    start(1, 4, 3);
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("bp_ovalid", out_valid, 1'b1);
      chk("bp_res", out_res, 32'hC0A00000);
      chk("bp_id", out_id, 2'd1);
      chk("bp_ready", req_ready, 4'b0000);
    end
    p0 = n_pop;
    out_ready = 1'b1;
    drain();
    chk("bp_count", n_pop - p0, 3);

    // reset with both stages full
    out_ready = 1'b0;
    start(1, 7, 1); start(2, 8, 1);
    step(); step(); step(); #1;
    chk("rm_busy_pre", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete(); gnt_log.delete();
    #1;
    chk("rm_ovalid", out_valid, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_res", out_res, 32'h0);
    chk("rm_id", out_id, 2'd0);
    out_ready = 1'b1;
    start(3, 8, 1); start(0, 9, 1);
    step();
    chk("rm_first_gnt", gl(0), 0);
    drain();

    // full contention: every requester issues twice
    gnt_log.delete();
    for (int i = 0; i < N; i++) start(i, i, 2);
    for (int k = 1; k <= 10; k++) begin
      step(); #1;
      if (k >= 2 && k <= 9) chk("thru_ovalid", out_valid, 1'b1);
    end
    for (int k = 0; k < 8; k++) chk("cont_gnt", gl(k), k % N);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_arb.md
Name: fp_mul_arb

Overview:
- Shares one combinational mul_para floating-point multiplier between NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Two-stage registered pipeline (issue register, result register) with full backpressure from a single result port.
- Sits between the vector/lane front-ends and the shared multiplier. Each result carries the requester index for routing back.

Parameters:
- SIGN_W, 1, sign field width passed to mul_para
- EXPO_W, 8, exponent field width passed to mul_para
- MANT_W, 23, mantissa field width passed to mul_para
- NUM_REQ, 4, number of requesters (>=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*FP_W  operand A, requester i at [i*FP_W +: FP_W]
- req_b  in  NUM_REQ*FP_W  operand B, same packing as req_a
- req_rnd  in  NUM_REQ*2  rounding mode per requester, passed unchanged to mul_para
- out_valid  out  1  result valid
- out_ready  in  1  result accepted by consumer
- out_res  out  FP_W  product
- out_id  out  ID_W  index of the requester that issued the operation
- busy  out  1  s1_valid | s2_valid

Behaviour:
- Widths: FP_W = SIGN_W+EXPO_W+MANT_W; ID_W = max(1, $clog2(NUM_REQ)).
- State: s1 {valid, a, b, rnd, id}; s2 {valid, res, id}; rr_ptr (ID_W bits).
- Reset (rst=1 at a clock edge): s1_valid=0, s2_valid=0, rr_ptr=0, out_res=0, out_id=0, all s1 data=0. This includes reset mid-operation: in-flight operations are dropped, no output is produced for them.
- Combinationally during reset: req_ready=0, out_valid=0.
- s2_adv = !s2_valid | out_ready.
- s1_adv = !s1_valid | s2_adv.
- Arbitration (combinational):
  - When s1_adv, the winner is the first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping mod NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - When !s1_adv or no request, req_ready=0.
  - req_ready never depends on req_a, req_b or req_rnd.
- Accept (req_valid[i] & req_ready[i]):
  - s1 <= {1, a_i, b_i, rnd_i, i}.
  - rr_ptr <= (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- s1_adv with no accept: s1_valid <= 0. rr_ptr unchanged.
- s1 hold (!s1_adv): s1 unchanged.
- Multiply: mul_para is driven directly from s1 a, b and rnd. Its combinational result is captured into s2 when s1_valid & s2_adv: s2 <= {1, res, s1_id}.
- s2_adv with !s1_valid: s2_valid <= 0. res and id hold their last values.
- Output mapping: out_valid = s2_valid; out_res = s2_res; out_id = s2_id.
- Latency: accept at edge N gives out_valid high after edge N+1, with no backpressure.
- Throughput: one operation per cycle.
- Backpressure: while out_valid & !out_ready, s2 holds. If s1 is also valid it holds and req_ready=0. No operation is lost or duplicated. Ordering is strictly FIFO by accept order.
- Simultaneous out_ready and a new accept in the same cycle: s2 takes s1 and s1 takes the new request (full-rate pass-through).
- Requesters must hold req_valid and operands stable until accepted. The block does not check this.

Decomposition:
- Package fp_mul_pkg:
  - SIGN_W/EXPO_W/MANT_W defaults and FP_W
  - rnd_t (2-bit)
  - localparam function for ID_W
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr, en; output one-hot grant and encoded index).
- mul_para is instantiated unchanged.

Test Plan:
- Single requester: req0 a=0x3F800000, b=0x40000000, rnd=2'b11, out_ready=1 -> req_ready[0]=1 at cycle 0. Two cycles later out_valid=1, out_res=0x40000000, out_id=0.
- Sign and rounding path: req2 a=0x3FC00000, b=0xC0000000 -> out_res=0xC0400000, out_id=2.
- Full contention: all 4 valid every cycle, out_ready=1 -> grant order 0,1,2,3,0,1. out_id follows the same order two cycles later. One result per cycle.
- Wrap: rr_ptr=3 (after granting 2); req3 and req0 valid -> grants 3 then 0. rr_ptr ends at 1.
- Backpressure: 3 operations issued; out_ready=0 for 4 cycles -> out_valid, out_res and out_id stable; s1 holds; req_ready=0. On release, 3 results are delivered in order with none lost or duplicated.
- Reset mid-operation: assert rst for 1 cycle while s1 and s2 are valid -> next cycle out_valid=0, busy=0, rr_ptr=0, out_res=0. The first request after reset is granted starting from index 0.
